mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_DATA_BITS, default 128, memory data beat width.
REQ-002 SHALL have parameter MEM_ADDR_BITS, default 28, memory line-address width.
REQ-003 SHALL have parameter BEATS, default 4, data beats per line transfer.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have client-0 (instruction cache) request ports:
- c0_req_val  input  1  request valid.
- c0_req_rdy  output  1  request accepted.
- c0_req_addr  input  MEM_ADDR_BITS  line address.
- c0_req_rw  input  1  1 = write, 0 = read.
REQ-007 SHALL have client-0 write-data and response ports:
- c0_req_data_valid  input  1  write beat valid.
- c0_req_data_ready  output  1  write beat accepted.
- c0_req_data_bits  input  MEM_DATA_BITS  write beat data.
- c0_req_data_mask  input  MEM_DATA_BITS/8  byte mask.
- c0_resp_val  output  1  read beat valid.
- c0_resp_data  output  MEM_DATA_BITS  read beat data.
REQ-008 SHALL have client-1 (data cache) ports identical to REQ-006/REQ-007 with prefix c1_.
REQ-009 SHALL have memory-side ports mirroring one client, directions reversed, prefix mem_: mem_req_val, mem_req_rdy, mem_req_addr, mem_req_rw, mem_req_data_valid, mem_req_data_ready, mem_req_data_bits, mem_req_data_mask, mem_resp_val, mem_resp_data.
REQ-010 SHALL have port protocol_err  output  1  sticky flag: unexpected mem_resp_val seen.

Function
REQ-011 SHALL implement states IDLE, WRITE and READ, plus a 1-bit owner register, a 1-bit round-robin pointer and a beat counter of width ceilLog2(BEATS).
REQ-012 In IDLE, SHALL grant c0 when only c0_req_val is high, c1 when only c1_req_val is high, and, when both are high, the client the pointer names.
REQ-013 In IDLE, SHALL drive mem_req_val, mem_req_addr and mem_req_rw from the granted client, combinationally in the same cycle.
REQ-014 SHALL drive cN_req_rdy = (state==IDLE) & grantN & mem_req_rdy; it SHALL hold the non-granted client's rdy at 0.
REQ-015 On an IDLE request handshake (mem_req_val & mem_req_rdy), SHALL latch owner, clear the beat counter, and go to WRITE if rw=1, else to READ.
REQ-016 Outside IDLE, SHALL drive mem_req_val=0 and both cN_req_rdy=0; new requests wait.
REQ-017 In WRITE:
- SHALL connect the owner's data_valid, data_bits and data_mask to mem_req_data_*.
- SHALL drive owner data_ready = mem_req_data_ready and non-owner data_ready = 0.
- SHALL increment the counter per beat handshake.
REQ-018 Write beats SHALL NOT be forwarded in the request-handshake cycle; the first beat is earliest one cycle later.
REQ-019 In READ:
- SHALL drive owner resp_val = mem_resp_val and non-owner resp_val = 0.
- SHALL drive both cN_resp_data = mem_resp_data.
- SHALL increment the counter per mem_resp_val cycle.
REQ-020 On the BEATS-th beat of WRITE or READ, SHALL return to IDLE the next cycle, clear the counter, and set the pointer to the non-owner.
REQ-021 Single-client traffic SHALL be served back-to-back regardless of the pointer.
REQ-022 In IDLE and WRITE, SHALL ignore mem_resp_val (both resp_val = 0) and set protocol_err, which stays 1 until reset.
REQ-023 Minimum occupancy SHALL be 1 request cycle + BEATS beat cycles; no combinational path SHALL exist from mem_resp_* to mem_req_*.

Reset
REQ-024 While reset=0, SHALL force state IDLE, counter 0, owner 0, pointer to c0 and protocol_err 0, asynchronously.
REQ-025 Reset SHALL hold every cN_req_rdy, cN_req_data_ready, cN_resp_val, mem_req_val and mem_req_data_valid at 0; data outputs are don't-care.
REQ-026 Reset asserted mid-transfer SHALL abandon the transfer; after reset=1 the first request starts in IDLE with counter 0.

Verification
REQ-027 Both clients read simultaneously after reset, mem_req_rdy=1 -> c0 granted first; c0 gets 4 resp_val beats; then c1 granted; c1_resp_val never high during c0 beats.
REQ-028 c1 writes addr 0x0000123 with 4 beats, mask 0xFFFF; memory stalls data_ready 2 cycles per beat -> exactly 4 beats forwarded in order; c0_req_rdy=0 throughout.
REQ-029 c0 requests while mem_req_rdy=0 for 5 cycles -> mem_req_val stays 1, addr stable; c0_req_rdy rises only in the handshake cycle.
REQ-030 mem_resp_val pulsed in IDLE -> no client resp_val; protocol_err=1 and stays 1 until reset.
REQ-031 reset=0 after 2 of 4 read beats, then reset=1 -> all valids 0; next c1 read completes a full 4 beats.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-client line-transfer arbiter: picks one of two cache clients per line, forwards the request,
// then streams BEATS write beats to memory or BEATS read beats back to the owning client.
module mem_arbiter #(
    parameter int MEM_DATA_BITS = 128,
    parameter int MEM_ADDR_BITS = 28,
    parameter int BEATS         = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       c0_req_val,
    output logic                       c0_req_rdy,
    input  logic [MEM_ADDR_BITS-1:0]   c0_req_addr,
    input  logic                       c0_req_rw,
    input  logic                       c0_req_data_valid,
    output logic                       c0_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   c0_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] c0_req_data_mask,
    output logic                       c0_resp_val,
    output logic [MEM_DATA_BITS-1:0]   c0_resp_data,

    input  logic                       c1_req_val,
    output logic                       c1_req_rdy,
    input  logic [MEM_ADDR_BITS-1:0]   c1_req_addr,
    input  logic                       c1_req_rw,
    input  logic                       c1_req_data_valid,
    output logic                       c1_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   c1_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] c1_req_data_mask,
    output logic                       c1_resp_val,
    output logic [MEM_DATA_BITS-1:0]   c1_resp_data,

    output logic                       mem_req_val,
    input  logic                       mem_req_rdy,
    output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    output logic                       mem_req_rw,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                       mem_resp_val,
    input  logic [MEM_DATA_BITS-1:0]   mem_resp_data,

    output logic                       protocol_err
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_owner, w_owner_nxt;
    logic             r_ptr, w_ptr_nxt;
    logic             r_err;

    logic w_idle, w_write, w_read;
    logic w_any_req, w_gnt1, w_req_hs, w_wbeat, w_rbeat, w_last;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_write = (r_state == ST_WRITE);
    assign w_read  = (r_state == ST_READ);

    // c1 wins when it is the only requester, or when both request and the pointer names it
    assign w_any_req = c0_req_val | c1_req_val;
    assign w_gnt1    = c1_req_val & (~c0_req_val | r_ptr);

    // Handshake outputs are gated with reset so nothing is offered while it is asserted
    assign mem_req_val  = reset & w_idle & w_any_req;
    assign mem_req_addr = w_gnt1 ? c1_req_addr : c0_req_addr;
    assign mem_req_rw   = w_gnt1 ? c1_req_rw   : c0_req_rw;
    assign c0_req_rdy   = mem_req_val & ~w_gnt1 & mem_req_rdy;
    assign c1_req_rdy   = mem_req_val &  w_gnt1 & mem_req_rdy;
    assign w_req_hs     = mem_req_val & mem_req_rdy;

    assign mem_req_data_valid = reset & w_write & (r_owner ? c1_req_data_valid : c0_req_data_valid);
    assign mem_req_data_bits  = r_owner ? c1_req_data_bits : c0_req_data_bits;
    assign mem_req_data_mask  = r_owner ? c1_req_data_mask : c0_req_data_mask;
    assign c0_req_data_ready  = reset & w_write & ~r_owner & mem_req_data_ready;
    assign c1_req_data_ready  = reset & w_write &  r_owner & mem_req_data_ready;
    assign w_wbeat            = mem_req_data_valid & mem_req_data_ready;

    assign c0_resp_val  = reset & w_read & ~r_owner & mem_resp_val;
    assign c1_resp_val  = reset & w_read &  r_owner & mem_resp_val;
    assign c0_resp_data = mem_resp_data;
    assign c1_resp_data = mem_resp_data;
    assign w_rbeat      = w_read & mem_resp_val;

    assign w_last       = (r_cnt == LAST_BEAT);
    assign protocol_err = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_req_hs) begin
                    w_owner_nxt = w_gnt1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = mem_req_rw ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE, ST_READ: begin
                if ((w_write && w_wbeat) || (w_read && w_rbeat)) begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_ptr_nxt   = ~r_owner;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            if (mem_resp_val && !w_read)
                r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration order, write stalls, request back-pressure,
// stray responses and mid-transfer reset, each checked against hand-computed values.
module tb_mem_arbiter;

    localparam int DW = 128;
    localparam int AW = 28;
    localparam int MW = DW / 8;

    logic          clk;
    logic          reset;
    logic          c0_req_val, c0_req_rdy, c0_req_rw;
    logic [AW-1:0] c0_req_addr;
    logic          c0_req_data_valid, c0_req_data_ready;
    logic [DW-1:0] c0_req_data_bits;
    logic [MW-1:0] c0_req_data_mask;
    logic          c0_resp_val;
    logic [DW-1:0] c0_resp_data;
    logic          c1_req_val, c1_req_rdy, c1_req_rw;
    logic [AW-1:0] c1_req_addr;
    logic          c1_req_data_valid, c1_req_data_ready;
    logic [DW-1:0] c1_req_data_bits;
    logic [MW-1:0] c1_req_data_mask;
    logic          c1_resp_val;
    logic [DW-1:0] c1_resp_data;
    logic          mem_req_val, mem_req_rdy, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_data_valid, mem_req_data_ready;
    logic [DW-1:0] mem_req_data_bits;
    logic [MW-1:0] mem_req_data_mask;
    logic          mem_resp_val;
    logic [DW-1:0] mem_resp_data;
    logic          protocol_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_wbeats;

    mem_arbiter #(.MEM_DATA_BITS(DW), .MEM_ADDR_BITS(AW), .BEATS(4)) dut (
        .clk(clk), .reset(reset),
        .c0_req_val(c0_req_val), .c0_req_rdy(c0_req_rdy), .c0_req_addr(c0_req_addr),
        .c0_req_rw(c0_req_rw), .c0_req_data_valid(c0_req_data_valid),
        .c0_req_data_ready(c0_req_data_ready), .c0_req_data_bits(c0_req_data_bits),
        .c0_req_data_mask(c0_req_data_mask), .c0_resp_val(c0_resp_val),
        .c0_resp_data(c0_resp_data),
        .c1_req_val(c1_req_val), .c1_req_rdy(c1_req_rdy), .c1_req_addr(c1_req_addr),
        .c1_req_rw(c1_req_rw), .c1_req_data_valid(c1_req_data_valid),
        .c1_req_data_ready(c1_req_data_ready), .c1_req_data_bits(c1_req_data_bits),
        .c1_req_data_mask(c1_req_data_mask), .c1_resp_val(c1_resp_val),
        .c1_resp_data(c1_resp_data),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
        .mem_req_data_mask(mem_req_data_mask), .mem_resp_val(mem_resp_val),
        .mem_resp_data(mem_resp_data),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rdata(input int unsigned i);
        return {4{32'hA5A5_0000 + i}};
    endfunction

    function automatic logic [DW-1:0] wdata(input int unsigned i);
        return {4{32'hD000_0000 + i}};
    endfunction

    initial begin
        reset = 1'b0;
        {c0_req_val, c0_req_rw, c0_req_data_valid} = '0;
        {c1_req_val, c1_req_rw, c1_req_data_valid} = '0;
        c0_req_addr = '0; c1_req_addr = '0;
        c0_req_data_bits = '0; c1_req_data_bits = '0;
        c0_req_data_mask = '0; c1_req_data_mask = '0;
        mem_req_rdy = 1'b0; mem_req_data_ready = 1'b0;
        mem_resp_val = 1'b0; mem_resp_data = '0;

        // Reset holds every handshake output low even with live inputs
        @(negedge clk);
        c0_req_val = 1'b1; c1_req_val = 1'b1; mem_req_rdy = 1'b1;
        c0_req_data_valid = 1'b1; mem_req_data_ready = 1'b1; mem_resp_val = 1'b1;
        #1;
        chk("rst_mem_req_val", mem_req_val, 0);
        chk("rst_c0_req_rdy", c0_req_rdy, 0);
        chk("rst_c1_req_rdy", c1_req_rdy, 0);
        chk("rst_c0_data_ready", c0_req_data_ready, 0);
        chk("rst_mem_data_valid", mem_req_data_valid, 0);
        chk("rst_c0_resp_val", c0_resp_val, 0);
        chk("rst_c1_resp_val", c1_resp_val, 0);
        chk("rst_protocol_err", protocol_err, 0);

        // Both clients read: c0 first, then c1 via the pointer while c0 still requests
        @(negedge clk);
        reset = 1'b1; mem_resp_val = 1'b0; c0_req_data_valid = 1'b0; mem_req_data_ready = 1'b0;
        c0_req_addr = 28'h0000111; c1_req_addr = 28'h0000222;
        #1;
        chk("rd0_mem_req_val", mem_req_val, 1);
        chk("rd0_addr", mem_req_addr, 28'h0000111);
        chk("rd0_rw", mem_req_rw, 0);
        chk("rd0_c0_rdy", c0_req_rdy, 1);
        chk("rd0_c1_rdy", c1_req_rdy, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_resp_val = 1'b1; mem_resp_data = rdata(i);
            #1;
            chk("rd0_c0_resp_val", c0_resp_val, 1);
            chk("rd0_c1_resp_val", c1_resp_val, 0);
            chk("rd0_c0_resp_data", c0_resp_data, rdata(i));
            chk("rd0_c1_resp_data", c1_resp_data, rdata(i));
            chk("rd0_busy_mem_req_val", mem_req_val, 0);
            chk("rd0_busy_c0_rdy", c0_req_rdy, 0);
        end
        @(negedge clk);
        mem_resp_val = 1'b0;
        #1;
        chk("rd1_addr", mem_req_addr, 28'h0000222);
        chk("rd1_c1_rdy", c1_req_rdy, 1);
        chk("rd1_c0_rdy", c0_req_rdy, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            c0_req_val = 1'b0; c1_req_val = 1'b0;
            mem_resp_val = 1'b1; mem_resp_data = rdata(i + 8);
            #1;
            chk("rd1_c1_resp_val", c1_resp_val, 1);
            chk("rd1_c0_resp_val", c0_resp_val, 0);
            chk("rd1_c1_resp_data", c1_resp_data, rdata(i + 8));
        end

        // Stray response in IDLE is dropped and latches the error flag
        @(negedge clk);
        mem_resp_val = 1'b1; mem_resp_data = rdata(99);
        #1;
        chk("stray_c0_resp_val", c0_resp_val, 0);
        chk("stray_c1_resp_val", c1_resp_val, 0);
        chk("stray_err_before_edge", protocol_err, 0);
        @(negedge clk);
        mem_resp_val = 1'b0;
        #1;
        chk("stray_err_set", protocol_err, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("stray_err_sticky", protocol_err, 1);

        // c1 line write with two stall cycles before each beat; c0 waits meanwhile
        c1_req_val = 1'b1; c1_req_rw = 1'b1; c1_req_addr = 28'h0000123;
        c1_req_data_valid = 1'b1; c1_req_data_bits = wdata(0); c1_req_data_mask = 16'hFFFF;
        mem_req_data_ready = 1'b1;
        #1;
        chk("wr_c1_rdy", c1_req_rdy, 1);
        chk("wr_rw", mem_req_rw, 1);
        chk("wr_addr", mem_req_addr, 28'h0000123);
        chk("wr_no_beat_in_hs", mem_req_data_valid, 0);
        chk("wr_no_ready_in_hs", c1_req_data_ready, 0);
        n_wbeats = 0;
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 3; s++) begin
                @(negedge clk);
                c1_req_val = 1'b0; c1_req_rw = 1'b0;
                c0_req_val = 1'b1; c0_req_rw = 1'b0; c0_req_addr = 28'h00000AA;
                c1_req_data_bits = wdata(i);
                mem_req_data_ready = (s == 2);
                #1;
                chk("wr_data_valid", mem_req_data_valid, 1);
                chk("wr_data_bits", mem_req_data_bits, wdata(i));
                chk("wr_data_mask", mem_req_data_mask, 16'hFFFF);
                chk("wr_c1_data_ready", c1_req_data_ready, (s == 2));
                chk("wr_c0_data_ready", c0_req_data_ready, 0);
                chk("wr_c0_rdy", c0_req_rdy, 0);
                chk("wr_mem_req_val", mem_req_val, 0);
                if (mem_req_data_valid && mem_req_data_ready) n_wbeats++;
            end
        end

        // c0 request held off by memory for five cycles
        @(negedge clk);
        c1_req_data_valid = 1'b0; mem_req_data_ready = 1'b0; mem_req_rdy = 1'b0;
        #1;
        chk("wr_beat_count", n_wbeats, 4);
        for (int k = 0; k < 5; k++) begin
            chk("bp_mem_req_val", mem_req_val, 1);
            chk("bp_addr", mem_req_addr, 28'h00000AA);
            chk("bp_c0_rdy", c0_req_rdy, 0);
            @(negedge clk);
            #1;
        end
        mem_req_rdy = 1'b1;
        #1;
        chk("bp_c0_rdy_hs", c0_req_rdy, 1);

        // Reset after two of four read beats abandons the transfer
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            c0_req_val = 1'b0; mem_resp_val = 1'b1; mem_resp_data = rdata(20 + i);
            #1;
            chk("ab_c0_resp_val", c0_resp_val, 1);
        end
        @(negedge clk);
        chk("ab_err_before_reset", protocol_err, 1);
        reset = 1'b0; c1_req_val = 1'b1;
        #1;
        chk("ab_rst_c0_resp_val", c0_resp_val, 0);
        chk("ab_rst_c1_resp_val", c1_resp_val, 0);
        chk("ab_rst_mem_req_val", mem_req_val, 0);
        chk("ab_rst_c1_rdy", c1_req_rdy, 0);
        chk("ab_rst_err", protocol_err, 0);
        @(negedge clk);
        reset = 1'b1; mem_resp_val = 1'b0; c1_req_rw = 1'b0; c1_req_addr = 28'h0000333;
        #1;
        chk("ab_c1_rdy", c1_req_rdy, 1);
        chk("ab_addr", mem_req_addr, 28'h0000333);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            c1_req_val = 1'b0; mem_resp_val = 1'b1; mem_resp_data = rdata(30 + i);
            #1;
            chk("ab_c1_resp_val", c1_resp_val, 1);
            chk("ab_c0_resp_val", c0_resp_val, 0);
        end
        @(negedge clk);
        mem_resp_val = 1'b0; c0_req_val = 1'b1; c0_req_addr = 28'h0000044;
        #1;
        chk("ab_idle_after_4", c0_req_rdy, 1);
        chk("ab_err_clear", protocol_err, 0);
        @(negedge clk);
        c0_req_val = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
